// File: rtl/countone_hls_deadlock_capture_ctrl.sv
// countone_hls_deadlock_capture_ctrl
// Arms on software request, debounces the monitor block flag for CONFIRM_CYCLES consecutive
// samples, then latches the AXIS block info plus a timestamp and raises a sticky interrupt.
// Counts confirmed deadlocks and rejected short pulses (both saturating).
// Optional feature: define DEADLOCK_CAPTURE_ACCUM_EN to OR together the info of every
// block-high sample in the confirm window instead of keeping only the first sample.
module countone_hls_deadlock_capture_ctrl #(
  parameter int unsigned INFO_WIDTH     = 9,
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned TS_WIDTH       = 32,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  clear,
  input  logic                  block,
  input  logic [INFO_WIDTH-1:0] axis_block_info,
  output logic [1:0]            state,
  output logic                  deadlock_irq,
  output logic [INFO_WIDTH-1:0] captured_info,
  output logic [TS_WIDTH-1:0]   capture_cycle,
  output logic [CNT_WIDTH-1:0]  deadlock_count,
  output logic [CNT_WIDTH-1:0]  glitch_count
);

  localparam int unsigned PersistWidth = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [PersistWidth-1:0] PersistDone = PersistWidth'(CONFIRM_CYCLES);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StConfirm = 2'd2,
    StLatched = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TS_WIDTH-1:0]     ts_q, ts_d, ts_inc;
  logic [PersistWidth-1:0] persist_q, persist_d, persist_inc;
  logic [INFO_WIDTH-1:0]   cand_info_q, cand_info_d;
  logic [TS_WIDTH-1:0]     cand_ts_q, cand_ts_d;
  logic [INFO_WIDTH-1:0]   captured_info_q, captured_info_d;
  logic [TS_WIDTH-1:0]     capture_cycle_q, capture_cycle_d;
  logic [CNT_WIDTH-1:0]    deadlock_count_q, deadlock_count_d;
  logic [CNT_WIDTH-1:0]    glitch_count_q, glitch_count_d;
  logic                    enter_latch;

  // Timestamp saturates rather than wrapping; persist cannot overflow since it stops at Done.
  assign ts_inc      = (ts_q == '1) ? ts_q : ts_q + TS_WIDTH'(1);
  assign persist_inc = persist_q + PersistWidth'(1);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every other transition
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    if (arm) state_d = StArmed;
        StArmed:   if (block) state_d = (CONFIRM_CYCLES == 1) ? StLatched : StConfirm;
        StConfirm: begin
          if (!block) begin
            state_d = StArmed;
          end else if (persist_inc == PersistDone) begin
            state_d = StLatched;
          end
        end
        StLatched: state_d = StLatched;
        default:   state_d = StIdle;
      endcase
    end
  end

  assign enter_latch = (state_d == StLatched) && (state_q != StLatched);

  // Datapath next-state: timestamp, candidate capture, result latch and counters
  always_comb begin
    ts_d             = ts_q;
    persist_d        = persist_q;
    cand_info_d      = cand_info_q;
    cand_ts_d        = cand_ts_q;
    captured_info_d  = captured_info_q;
    capture_cycle_d  = capture_cycle_q;
    deadlock_count_d = deadlock_count_q;
    glitch_count_d   = glitch_count_q;
    if (clear) begin
      persist_d   = '0;
      cand_info_d = '0;
      cand_ts_d   = '0;
    end else begin
      case (state_q)
        StIdle: if (arm) ts_d = '0;
        StArmed: begin
          ts_d = ts_inc;
          if (block) begin
            cand_info_d = axis_block_info;
            cand_ts_d   = ts_q;
            persist_d   = PersistWidth'(1);
          end
        end
        StConfirm: begin
          ts_d = ts_inc;
          if (block) begin
            persist_d = persist_inc;
`ifdef DEADLOCK_CAPTURE_ACCUM_EN
            cand_info_d = cand_info_q | axis_block_info;
`endif
          end else begin
            // Short pulse: count it and drop the candidate
            glitch_count_d = (glitch_count_q == '1) ? glitch_count_q
                                                    : glitch_count_q + CNT_WIDTH'(1);
            persist_d   = '0;
            cand_info_d = '0;
            cand_ts_d   = '0;
          end
        end
        default: ;
      endcase
    end
    // Latch from the next-cycle candidate so a single-sample confirm captures this cycle's info
    if (enter_latch) begin
      captured_info_d  = cand_info_d;
      capture_cycle_d  = cand_ts_d;
      deadlock_count_d = (deadlock_count_q == '1) ? deadlock_count_q
                                                  : deadlock_count_q + CNT_WIDTH'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q             <= '0;
      persist_q        <= '0;
      cand_info_q      <= '0;
      cand_ts_q        <= '0;
      captured_info_q  <= '0;
      capture_cycle_q  <= '0;
      deadlock_count_q <= '0;
      glitch_count_q   <= '0;
    end else begin
      ts_q             <= ts_d;
      persist_q        <= persist_d;
      cand_info_q      <= cand_info_d;
      cand_ts_q        <= cand_ts_d;
      captured_info_q  <= captured_info_d;
      capture_cycle_q  <= capture_cycle_d;
      deadlock_count_q <= deadlock_count_d;
      glitch_count_q   <= glitch_count_d;
    end
  end

  // Outputs
  always_comb begin
    state          = state_q;
    deadlock_irq   = (state_q == StLatched);
    captured_info  = captured_info_q;
    capture_cycle  = capture_cycle_q;
    deadlock_count = deadlock_count_q;
    glitch_count   = glitch_count_q;
  end

endmodule

// File: tb/tb_countone_hls_deadlock_capture_ctrl.sv
// Bench for countone_hls_deadlock_capture_ctrl: table of stimulus segments with expected
// outputs pushed to a scoreboard queue, plus hand-written sequences for reset, counter
// saturation (CNT_WIDTH=2) and single-sample confirm (CONFIRM_CYCLES=1).
module tb_countone_hls_deadlock_capture_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Main instance, default parameters
  logic       arm = 0, clear = 0, block = 0;
  logic [8:0] info = '0;
  logic [1:0] st_m;
  logic       irq_m;
  logic [8:0] cap_m;
  logic [31:0] cyc_m;
  logic [7:0] dc_m, gc_m;

  countone_hls_deadlock_capture_ctrl dut_m (
    .clock(clock), .reset_n(reset_n), .arm(arm), .clear(clear), .block(block),
    .axis_block_info(info), .state(st_m), .deadlock_irq(irq_m), .captured_info(cap_m),
    .capture_cycle(cyc_m), .deadlock_count(dc_m), .glitch_count(gc_m)
  );

  // Narrow-counter instance
  logic       arm_c = 0, clear_c = 0, block_c = 0;
  logic [8:0] info_c = '0;
  logic [1:0] st_c;
  logic       irq_c;
  logic [8:0] cap_c;
  logic [31:0] cyc_c;
  logic [1:0] dc_c, gc_c;

  countone_hls_deadlock_capture_ctrl #(.CONFIRM_CYCLES(4), .CNT_WIDTH(2)) dut_c (
    .clock(clock), .reset_n(reset_n), .arm(arm_c), .clear(clear_c), .block(block_c),
    .axis_block_info(info_c), .state(st_c), .deadlock_irq(irq_c), .captured_info(cap_c),
    .capture_cycle(cyc_c), .deadlock_count(dc_c), .glitch_count(gc_c)
  );

  // Single-sample confirm instance
  logic       arm_o = 0, clear_o = 0, block_o = 0;
  logic [8:0] info_o = '0;
  logic [1:0] st_o;
  logic       irq_o;
  logic [8:0] cap_o;
  logic [31:0] cyc_o;
  logic [7:0] dc_o, gc_o;

  countone_hls_deadlock_capture_ctrl #(.CONFIRM_CYCLES(1)) dut_o (
    .clock(clock), .reset_n(reset_n), .arm(arm_o), .clear(clear_o), .block(block_o),
    .axis_block_info(info_o), .state(st_o), .deadlock_irq(irq_o), .captured_info(cap_o),
    .capture_cycle(cyc_o), .deadlock_count(dc_o), .glitch_count(gc_o)
  );

`ifdef DEADLOCK_CAPTURE_ACCUM_EN
  localparam logic [8:0] AccCap = 9'h1FF;
`else
  localparam logic [8:0] AccCap = 9'h1F8;
`endif

  typedef struct {
    string       name;
    bit          arm, clear, block;
    logic [8:0]  info;
    int          n;
    logic [1:0]  st;
    logic        irq;
    logic [8:0]  cap;
    logic [31:0] cyc;
    logic [7:0]  dc, gc;
  } vec_t;

  vec_t tbl[16];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(string nm, bit a, bit c, bit b, logic [8:0] inf, int n,
                              logic [1:0] st, logic irq, logic [8:0] cap, logic [31:0] cyc,
                              logic [7:0] dc, logic [7:0] gc);
    vec_t v;
    v.name = nm; v.arm = a; v.clear = c; v.block = b; v.info = inf; v.n = n;
    v.st = st; v.irq = irq; v.cap = cap; v.cyc = cyc; v.dc = dc; v.gc = gc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the main instance outputs
  task automatic sb_check();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: got empty queue expected a record");
      return;
    end
    e = exp_q.pop_front();
    chk({e.name, ".state"}, 32'(st_m), 32'(e.st));
    chk({e.name, ".irq"}, 32'(irq_m), 32'(e.irq));
    chk({e.name, ".captured_info"}, 32'(cap_m), 32'(e.cap));
    chk({e.name, ".capture_cycle"}, cyc_m, e.cyc);
    chk({e.name, ".deadlock_count"}, 32'(dc_m), 32'(e.dc));
    chk({e.name, ".glitch_count"}, 32'(gc_m), 32'(e.gc));
  endtask

  // Drive one segment for n cycles, then compare just after the last sampling edge
  task automatic run_seg(input vec_t v);
    exp_q.push_back(v);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clock);
      arm = v.arm; clear = v.clear; block = v.block; info = v.info;
    end
    @(posedge clock);
    #1;
    arm = 0; clear = 0;
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    //            name         arm clr blk info   n  st irq cap     cyc dc gc
    tbl[0]  = mk("reset",      0, 0, 0, 9'h000, 1, 0, 0, 9'h000, 0,  0, 0);
    tbl[1]  = mk("arm",        1, 0, 0, 9'h000, 1, 1, 0, 9'h000, 0,  0, 0);
    tbl[2]  = mk("wait20",     0, 0, 0, 9'h000, 20, 1, 0, 9'h000, 0, 0, 0);
    tbl[3]  = mk("high15",     0, 0, 1, 9'h1F8, 15, 2, 0, 9'h000, 0, 0, 0);
    tbl[4]  = mk("high16",     0, 0, 1, 9'h1F8, 1, 3, 1, 9'h1F8, 20, 1, 0);
    tbl[5]  = mk("hold",       0, 0, 0, 9'h000, 3, 3, 1, 9'h1F8, 20, 1, 0);
    tbl[6]  = mk("clear",      0, 1, 0, 9'h000, 1, 0, 0, 9'h1F8, 20, 1, 0);
    tbl[7]  = mk("arm_clr",    1, 1, 0, 9'h000, 1, 0, 0, 9'h1F8, 20, 1, 0);
    tbl[8]  = mk("rearm",      1, 0, 0, 9'h000, 1, 1, 0, 9'h1F8, 20, 1, 0);
    tbl[9]  = mk("short5",     0, 0, 1, 9'h007, 5, 2, 0, 9'h1F8, 20, 1, 0);
    tbl[10] = mk("glitch",     0, 0, 0, 9'h000, 1, 1, 0, 9'h1F8, 20, 1, 1);
    tbl[11] = mk("arm_ignore", 1, 0, 0, 9'h000, 1, 1, 0, 9'h1F8, 20, 1, 1);
    tbl[12] = mk("acc_first",  0, 0, 1, 9'h1F8, 1, 2, 0, 9'h1F8, 20, 1, 1);
    tbl[13] = mk("acc_rest",   0, 0, 1, 9'h03F, 15, 3, 1, AccCap, 7, 2, 1);
    tbl[14] = mk("clear2",     0, 1, 0, 9'h000, 1, 0, 0, AccCap, 7, 2, 1);
    tbl[15] = mk("idle_block", 0, 0, 1, 9'h0AA, 3, 0, 0, AccCap, 7, 2, 1);

    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) run_seg(tbl[i]);

    // Asynchronous reset in the middle of a confirm window, checked before any clock edge
    run_seg(mk("arm3", 1, 0, 0, 9'h000, 1, 1, 0, AccCap, 7, 2, 1));
    run_seg(mk("high3", 0, 0, 1, 9'h111, 3, 2, 0, AccCap, 7, 2, 1));
    @(negedge clock);
    block = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async.state", 32'(st_m), 0);
    chk("async.irq", 32'(irq_m), 0);
    chk("async.captured_info", 32'(cap_m), 0);
    chk("async.capture_cycle", cyc_m, 0);
    chk("async.deadlock_count", 32'(dc_m), 0);
    chk("async.glitch_count", 32'(gc_m), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Five short pulses against a 2-bit glitch counter
    @(negedge clock); arm_c = 1;
    @(negedge clock); arm_c = 0;
    for (int g = 0; g < 5; g++) begin
      block_c = 1; info_c = 9'h007;
      @(negedge clock);
      @(negedge clock); block_c = 0; info_c = 0;
      @(negedge clock);
    end
    chk("sat.glitch_count", 32'(gc_c), 3);
    chk("sat.state", 32'(st_c), 1);
    chk("sat.deadlock_count", 32'(dc_c), 0);
    block_c = 1; info_c = 9'h100;
    repeat (4) @(negedge clock);
    block_c = 0; info_c = 0;
    chk("sat.latch_state", 32'(st_c), 3);
    chk("sat.latch_irq", 32'(irq_c), 1);
    chk("sat.latch_info", 32'(cap_c), 32'h100);

    // Single-sample confirm goes straight from ARMED to LATCHED
    @(negedge clock); arm_o = 1;
    @(negedge clock); arm_o = 0;
    @(negedge clock);
    @(negedge clock); block_o = 1; info_o = 9'h055;
    @(negedge clock); block_o = 0; info_o = 0;
    chk("one.state", 32'(st_o), 3);
    chk("one.irq", 32'(irq_o), 1);
    chk("one.captured_info", 32'(cap_o), 32'h055);
    chk("one.capture_cycle", cyc_o, 2);
    chk("one.deadlock_count", 32'(dc_o), 1);
    chk("one.glitch_count", 32'(gc_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
